// File: rtl/tri_bbox_walker.sv
// Triangle bounding-box pixel walker: latches one projected triangle, clips its box to the screen
// and streams every covered pixel in raster order. Optional macro RAST_DEGEN_CULL_EN drops zero-area triangles.
module tri_bbox_walker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tri_valid,
    output logic             tri_ready,
    input  logic [2:0][35:0] proj_vertex_in,
    input  logic [1:0]       set_in,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [10:0]      x,
    output logic [10:0]      y,
    output logic [1:0]       set,
    output logic [2:0][35:0] proj_vertex_out,
    output logic             pix_last,
    output logic             busy,
    output logic             tri_done
);

    localparam logic [10:0] X_LIM = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y_LIM = 11'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    function automatic logic [10:0] min3(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return {1'b0, m};
    endfunction

    function automatic logic [10:0] max3(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return {1'b0, m};
    endfunction

    function automatic logic [10:0] clip_hi(input logic [10:0] v, input logic [10:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [2:0][9:0] vx, vy;
    logic [10:0]     xmin_p0, xmax_p0, ymin_p0, ymax_p0;
    logic [10:0]     xmin_p1, xmax_p1, ymin_p1, ymax_p1;
    logic            off_screen_p0;
    logic            degen_p0;
    logic            cull_p0;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vx[i] = proj_vertex_out[i][35:26];
            vy[i] = proj_vertex_out[i][25:16];
        end
    end

    // Setup stage: box of the latched vertices, upper edges clipped to the screen
    assign xmin_p0 = min3(vx[0], vx[1], vx[2]);
    assign ymin_p0 = min3(vy[0], vy[1], vy[2]);
    assign xmax_p0 = clip_hi(max3(vx[0], vx[1], vx[2]), X_LIM);
    assign ymax_p0 = clip_hi(max3(vy[0], vy[1], vy[2]), Y_LIM);
    assign off_screen_p0 = (xmin_p0 > xmax_p0) || (ymin_p0 > ymax_p0);

`ifdef RAST_DEGEN_CULL_EN
    logic signed [10:0] dx02, dy12, dy02, dx12;
    logic signed [21:0] area_p0;

    // Deltas of two 10-bit unsigned values always fit 11-bit signed; the area fits 22-bit signed.
    assign dx02 = $signed({1'b0, vx[0]}) - $signed({1'b0, vx[2]});
    assign dy12 = $signed({1'b0, vy[1]}) - $signed({1'b0, vy[2]});
    assign dy02 = $signed({1'b0, vy[0]}) - $signed({1'b0, vy[2]});
    assign dx12 = $signed({1'b0, vx[1]}) - $signed({1'b0, vx[2]});
    assign area_p0 = 22'(dx02) * 22'(dy12) - 22'(dy02) * 22'(dx12);
    assign degen_p0 = (area_p0 == 22'sd0);
`else
    assign degen_p0 = 1'b0;
`endif

    assign cull_p0 = off_screen_p0 || degen_p0;

    // Gated with WALK so the reset-time x/y/box values never report a last pixel.
    assign pix_last = (state == WALK) && (x == xmax_p1) && (y == ymax_p1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tri_ready = 1'b0;
        pix_valid = 1'b0;
        busy      = 1'b1;
        tri_done  = 1'b0;
        case (state)
            IDLE: begin
                tri_ready = 1'b1;
                busy      = 1'b0;
                if (tri_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = cull_p0 ? DONE : WALK;
            end
            WALK: begin
                pix_valid = 1'b1;
                if (pix_ready && pix_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                tri_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x               <= '0;
            y               <= '0;
            set             <= '0;
            proj_vertex_out <= '0;
            xmin_p1         <= '0;
            xmax_p1         <= '0;
            ymin_p1         <= '0;
            ymax_p1         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tri_valid) begin
                        proj_vertex_out <= proj_vertex_in;
                        set             <= set_in;
                    end
                end
                SETUP: begin
                    xmin_p1 <= xmin_p0;
                    xmax_p1 <= xmax_p0;
                    ymin_p1 <= ymin_p0;
                    ymax_p1 <= ymax_p0;
                    if (!cull_p0) begin
                        x <= xmin_p0;
                        y <= ymin_p0;
                    end
                end
                // Walk stage: x/y only move on an accepted pixel, so stalls hold them bit-stable
                WALK: begin
                    if (pix_ready) begin
                        if (x == xmax_p1) begin
                            x <= xmin_p1;
                            if (y != ymax_p1) begin
                                y <= y + 11'd1;
                            end
                        end else begin
                            x <= x + 11'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
